// File: rtl/seq_detect_param_pkg.sv
// rtl/seq_detect_param_pkg.sv - shared defaults and width helper for the serial pattern detector
package seq_detect_param_pkg;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W   = 8;

   // Width needed to hold a pattern length of 0..max_len inclusive.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// rtl/seq_detect_param_sat_counter.sv - saturating match counter with clear and sticky saturation flag
module seq_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count,
   output logic             o_sat
);

   localparam logic [CNT_W-1:0] C_MAX  = '1;
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_NEAR = C_MAX - C_ONE;

   logic [CNT_W-1:0] r_count;
   logic             r_sat;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (i_clr) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (i_inc && (r_count != C_MAX)) begin
         r_count <= r_count + C_ONE;
         if (r_count == C_NEAR) r_sat <= 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_sat   = r_sat;

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-programmable serial bit-pattern detector with saturating match count
module seq_detect_param
   import seq_detect_param_pkg::*;
#(
   parameter  int MAX_LEN = DEF_MAX_LEN,
   parameter  int CNT_W   = DEF_CNT_W,
   localparam int LEN_W   = len_width(MAX_LEN)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_cfg_load,
   input  logic [MAX_LEN-1:0] i_cfg_pattern,
   input  logic [LEN_W-1:0]   i_cfg_len,
   input  logic               i_cfg_overlap,
   input  logic               i_inp_valid,
   input  logic               i_inp_bit,
   output logic               o_seq_seen,
   output logic [CNT_W-1:0]   o_match_count,
   output logic               o_count_sat,
   output logic               o_cfg_err
);

   localparam logic [LEN_W-1:0] C_FULL = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] C_ONE  = LEN_W'(1);

   logic [MAX_LEN-1:0] r_hist;
   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_fill;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic               r_seq_seen;
   logic               r_cfg_err;

   logic               w_accept;
   logic [MAX_LEN-1:0] w_hist_next;
   logic [LEN_W-1:0]   w_fill_next;
   logic [MAX_LEN-1:0] w_mask;
   logic               w_match;

   assign w_accept    = i_inp_valid && !i_cfg_load && !r_cfg_err;
   assign w_hist_next = {r_hist[MAX_LEN-2:0], i_inp_bit};
   assign w_fill_next = (r_fill == C_FULL) ? r_fill : (r_fill + C_ONE);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(r_len)) w_mask[i] = 1'b1;
      end
   end

   // Comparing the whole masked history covers partial-match restarts without prefix tracking.
   assign w_match = w_accept && (w_fill_next >= r_len) &&
                    ((w_hist_next & w_mask) == (r_pattern & w_mask));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hist     <= '0;
         r_pattern  <= '0;
         r_fill     <= '0;
         r_len      <= '0;
         r_overlap  <= 1'b0;
         r_seq_seen <= 1'b0;
         r_cfg_err  <= 1'b1;
      end else if (i_cfg_load) begin
         r_hist     <= '0;
         r_pattern  <= i_cfg_pattern;
         r_fill     <= '0;
         r_len      <= i_cfg_len;
         r_overlap  <= i_cfg_overlap;
         r_seq_seen <= 1'b0;
         r_cfg_err  <= (i_cfg_len == '0) || (i_cfg_len > C_FULL);
      end else if (w_accept) begin
         r_hist     <= w_hist_next;
         r_fill     <= (w_match && !r_overlap) ? '0 : w_fill_next;
         r_seq_seen <= w_match;
      end else begin
         r_seq_seen <= 1'b0;
      end
   end

   seq_sat_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_cfg_load),
      .i_inc   (w_match),
      .o_count (o_match_count),
      .o_sat   (o_count_sat)
   );

   assign o_seq_seen = r_seq_seen;
   assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param (default and CNT_W=2 instances)
module tb_seq_detect_param;

   typedef struct {
      int count;
      bit sat;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       cfg_load;
   logic       cfg_load2;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       inp_valid;
   logic       inp_bit;

   logic       seq_seen,  count_sat,  cfg_err;
   logic [7:0] match_count;
   logic       seq_seen2, count_sat2, cfg_err2;
   logic [1:0] match_count2;

   exp_t q1[$];
   exp_t q2[$];
   int   checks = 0;
   int   errors = 0;

   seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_cfg_load    (cfg_load),
      .i_cfg_pattern (cfg_pattern),
      .i_cfg_len     (cfg_len),
      .i_cfg_overlap (cfg_overlap),
      .i_inp_valid   (inp_valid),
      .i_inp_bit     (inp_bit),
      .o_seq_seen    (seq_seen),
      .o_match_count (match_count),
      .o_count_sat   (count_sat),
      .o_cfg_err     (cfg_err)
   );

   seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_cfg_load    (cfg_load2),
      .i_cfg_pattern (cfg_pattern),
      .i_cfg_len     (cfg_len),
      .i_cfg_overlap (cfg_overlap),
      .i_inp_valid   (inp_valid),
      .i_inp_bit     (inp_bit),
      .o_seq_seen    (seq_seen2),
      .o_match_count (match_count2),
      .o_count_sat   (count_sat2),
      .o_cfg_err     (cfg_err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitors: every seq_seen pulse must consume one expected entry.
   always @(negedge clk) begin
      if (seq_seen) begin
         exp_t e;
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_seq_seen count %0d at %0t", match_count, $time);
         end else begin
            e = q1.pop_front();
            chk("match_count", int'(match_count), e.count);
            chk("count_sat", int'(count_sat), int'(e.sat));
         end
      end
   end

   always @(negedge clk) begin
      if (seq_seen2) begin
         exp_t e;
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_seq_seen2 count %0d at %0t", match_count2, $time);
         end else begin
            e = q2.pop_front();
            chk("match_count2", int'(match_count2), e.count);
            chk("count_sat2", int'(count_sat2), int'(e.sat));
         end
      end
   end

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov,
                       input logic both, input logic v);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      cfg_load    = 1'b1;
      cfg_load2   = both;
      inp_valid   = v;
      inp_bit     = 1'b1;
      @(posedge clk);
      #1;
      cfg_load  = 1'b0;
      cfg_load2 = 1'b0;
      inp_valid = 1'b0;
   endtask

   task automatic send(input logic b, input bit m, input int c, input bit s,
                       input bit m2, input int c2, input bit s2);
      exp_t e;
      if (m) begin
         e.count = c;
         e.sat   = s;
         q1.push_back(e);
      end
      if (m2) begin
         e.count = c2;
         e.sat   = s2;
         q2.push_back(e);
      end
      inp_valid = 1'b1;
      inp_bit   = b;
      @(posedge clk);
      #1;
      inp_valid = 1'b0;
   endtask

   task automatic bits(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send(v[i], 0, 0, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drained(input string name);
      idle(2);
      chk({name, "_pending1"}, q1.size(), 0);
      chk({name, "_pending2"}, q2.size(), 0);
      q1.delete();
      q2.delete();
   endtask

   initial begin
      rst_n = 1'b0; cfg_load = 1'b0; cfg_load2 = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      inp_valid = 1'b0; inp_bit = 1'b0;
      #12;
      chk("rst_seq_seen", int'(seq_seen), 0);
      chk("rst_count", int'(match_count), 0);
      chk("rst_sat", int'(count_sat), 0);
      chk("rst_cfg_err", int'(cfg_err), 1);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // 1: overlapping 1011 on 1011011
      load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
      chk("t1_cfg_err", int'(cfg_err), 0);
      bits(8'b101, 3);
      send(1, 1, 1, 0, 0, 0, 0);
      bits(8'b01, 2);
      send(1, 1, 2, 0, 0, 0, 0);
      drained("t1");
      chk("t1_count", int'(match_count), 2);

      // 2: non-overlapping
      load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0);
      chk("t2_count_clr", int'(match_count), 0);
      bits(8'b101, 3);
      send(1, 1, 1, 0, 0, 0, 0);
      bits(8'b011, 3);
      drained("t2");
      chk("t2_count", int'(match_count), 1);

      // 3: repeated-1 prefix then restart
      load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
      bits(8'b1101, 4);
      send(1, 1, 1, 0, 0, 0, 0);
      bits(8'b01, 2);
      send(1, 1, 2, 0, 0, 0, 0);
      drained("t3");

      // 3b: a bit presented during cfg_load is not accepted
      load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b1);
      bits(8'b011, 3);
      drained("t3b");
      chk("t3b_count", int'(match_count), 0);

      // 4: reset mid-pattern discards history and count
      load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
      bits(8'b101, 3);
      send(1, 1, 1, 0, 0, 0, 0);
      bits(8'b01, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_rst_seq_seen", int'(seq_seen), 0);
      chk("t4_rst_count", int'(match_count), 0);
      chk("t4_rst_sat", int'(count_sat), 0);
      chk("t4_rst_cfg_err", int'(cfg_err), 1);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
      bits(8'b1, 1);
      drained("t4");
      chk("t4_count", int'(match_count), 0);

      // 5: len 1 with gaps; CNT_W=2 instance saturates at 3
      load(8'h01, 4'd1, 1'b0, 1'b1, 1'b0);
      chk("t5_cfg_err2", int'(cfg_err2), 0);
      send(1, 1, 1, 0, 1, 1, 0);
      idle(2);
      send(1, 1, 2, 0, 1, 2, 0);
      idle(1);
      send(0, 0, 0, 0, 0, 0, 0);
      send(1, 1, 3, 0, 1, 3, 1);
      idle(3);
      send(1, 1, 4, 0, 1, 3, 1);
      send(1, 1, 5, 0, 1, 3, 1);
      drained("t5");
      chk("t5_sat2", int'(count_sat2), 1);
      chk("t5_count2", int'(match_count2), 3);
      load(8'h01, 4'd0, 1'b0, 1'b1, 1'b0);
      chk("t5_clr_count2", int'(match_count2), 0);
      chk("t5_clr_sat2", int'(count_sat2), 0);
      chk("t5_clr_count", int'(match_count), 0);

      // 6: illegal lengths disable the detector; then full-length A5
      chk("t6_err_len0", int'(cfg_err), 1);
      bits(8'b1101, 4);
      load(8'h01, 4'd9, 1'b1, 1'b0, 1'b0);
      chk("t6_err_len9", int'(cfg_err), 1);
      bits(8'b101, 3);
      drained("t6_illegal");
      load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
      chk("t6_cfg_err", int'(cfg_err), 0);
      bits(8'b1010010, 7);
      send(1, 1, 1, 0, 0, 0, 0);
      drained("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
